// File: rtl/ttt_stage_sequencer_pkg.sv
// Shared types and constants for the ttt stage sequencer and the main datapath.
// Stage codes here are the values the datapath decodes on its stage input.
package ttt_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PROG    = 3'd1,
        ST_INPUT   = 3'd2,
        ST_PROCESS = 3'd3,
        ST_OUTPUT  = 3'd4,
        ST_DONE    = 3'd5
    } seq_state_t;

    localparam logic [4:0] INSTR_NOP = 5'd0;

    localparam logic [2:0] STAGE_IDLE    = 3'd0;
    localparam logic [2:0] STAGE_PROG    = 3'd1;
    localparam logic [2:0] STAGE_INPUT   = 3'd2;
    localparam logic [2:0] STAGE_PROCESS = 3'd3;
    localparam logic [2:0] STAGE_OUTPUT  = 3'd4;
    localparam logic [2:0] STAGE_DONE    = 3'd5;

endpackage

// File: rtl/ttt_stage_sequencer_if.sv
// Bundle between host shim / datapath (slave side) and the stage sequencer (master side).
// TTT_SEQ_AUTORUN_EN adds the autorun request line.
interface ttt_seq_if #(
    parameter int NUM_PROCESSORS = 10,
    parameter int PROG_WIDTH     = 8,
    parameter int EVT_CNT_BITS   = 8
);
    localparam int PID_W = $clog2(NUM_PROCESSORS);

`ifdef TTT_SEQ_AUTORUN_EN
    logic                    autorun;
`endif
    logic                    start;
    logic                    prog_req;
    logic [4:0]              prog_instr_in;
    logic [PROG_WIDTH-1:0]   prog_data_in;
    logic                    prog_ack;
    logic                    in_valid;
    logic                    in_last;
    logic                    in_ready;
    logic                    dp_output_valid;
    logic                    out_ready;
    logic [2:0]              stage;
    logic [PID_W-1:0]        processor_id;
    logic [4:0]              instruction;
    logic [PROG_WIDTH-1:0]   prog_data;
    logic                    busy;
    logic                    tick_done;
    logic [EVT_CNT_BITS-1:0] evt_count;

    modport master (
`ifdef TTT_SEQ_AUTORUN_EN
        input  autorun,
`endif
        input  start, prog_req, prog_instr_in, prog_data_in,
        input  in_valid, in_last, dp_output_valid, out_ready,
        output prog_ack, in_ready, stage, processor_id, instruction,
        output prog_data, busy, tick_done, evt_count
    );

    modport slave (
`ifdef TTT_SEQ_AUTORUN_EN
        output autorun,
`endif
        output start, prog_req, prog_instr_in, prog_data_in,
        output in_valid, in_last, dp_output_valid, out_ready,
        input  prog_ack, in_ready, stage, processor_id, instruction,
        input  prog_data, busy, tick_done, evt_count
    );

endinterface

// File: rtl/ttt_stage_sequencer_scan_counter.sv
// Modulo-COUNT index counter shared by the PROCESS and OUTPUT scans.
// Wraps explicitly so non-power-of-2 counts never exceed COUNT-1.
module ttt_scan_counter #(
    parameter int COUNT = 10,
    parameter int W     = $clog2(COUNT)
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         last_o
);
    localparam logic [W-1:0] LAST = W'(COUNT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)       cnt_d = '0;
        else if (en_i)   cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign cnt_o  = cnt_q;
    assign last_o = (cnt_q == LAST);

endmodule

// File: rtl/ttt_stage_sequencer.sv
// Stage sequencer: runs one tick input -> process -> output and arbitrates host writes.
// Optional TTT_SEQ_AUTORUN_EN lets DONE chain straight into the next INPUT.
module ttt_stage_sequencer
    import ttt_seq_pkg::*;
#(
    parameter int NUM_PROCESSORS = 10,
    parameter int PROG_WIDTH     = 8,
    parameter int EVT_CNT_BITS   = 8
) (
    input  logic  clock,
    input  logic  reset,
    ttt_seq_if.master bus
);
    localparam int PID_W = $clog2(NUM_PROCESSORS);

    seq_state_t              state_q, state_d;
    logic [4:0]              instr_q;
    logic [PROG_WIDTH-1:0]   prog_data_q;
    logic [EVT_CNT_BITS-1:0] evt_q, evt_d, evt_count_q;
    logic [PID_W-1:0]        pid;
    logic                    pid_last, scan_adv, scan_clr, evt_hit;

    function automatic logic [EVT_CNT_BITS-1:0] sat_inc(input logic [EVT_CNT_BITS-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // OUTPUT only stalls when a valid event is waiting on downstream.
    assign scan_adv = (state_q == ST_PROCESS) ||
                      ((state_q == ST_OUTPUT) && !(bus.dp_output_valid && !bus.out_ready));
    assign scan_clr = (state_q != ST_PROCESS) && (state_q != ST_OUTPUT);
    assign evt_hit  = (state_q == ST_OUTPUT) && bus.dp_output_valid && bus.out_ready;

    ttt_scan_counter #(.COUNT(NUM_PROCESSORS), .W(PID_W)) u_scan (
        .clk_i   (clock),
        .rst_n_i (reset),
        .clr_i   (scan_clr),
        .en_i    (scan_adv),
        .cnt_o   (pid),
        .last_o  (pid_last)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (bus.prog_req)     state_d = ST_PROG;
                        else if (bus.start)   state_d = ST_INPUT;
            ST_PROG:    state_d = ST_IDLE;
            ST_INPUT:   if (bus.in_valid && bus.in_last) state_d = ST_PROCESS;
            ST_PROCESS: if (pid_last)         state_d = ST_OUTPUT;
            ST_OUTPUT:  if (scan_adv && pid_last) state_d = ST_DONE;
`ifdef TTT_SEQ_AUTORUN_EN
            ST_DONE:    if (bus.autorun)      state_d = bus.prog_req ? ST_PROG : ST_INPUT;
                        else                  state_d = ST_IDLE;
`else
            ST_DONE:    state_d = ST_IDLE;
`endif
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        evt_d = evt_q;
        if ((state_d == ST_INPUT) && (state_q != ST_INPUT)) evt_d = '0;
        else if (evt_hit)                                   evt_d = sat_inc(evt_q);
    end

    // Published count includes an event taken on the final OUTPUT cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            instr_q     <= INSTR_NOP;
            prog_data_q <= '0;
            evt_q       <= '0;
            evt_count_q <= '0;
        end else begin
            instr_q <= (state_d == ST_PROG) ? bus.prog_instr_in : INSTR_NOP;
            if (state_d == ST_PROG) prog_data_q <= bus.prog_data_in;
            evt_q <= evt_d;
            if (state_d == ST_DONE) evt_count_q <= evt_d;
        end
    end

    always_comb begin
        bus.stage        = state_q;
        bus.processor_id = pid;
        bus.instruction  = instr_q;
        bus.prog_data    = prog_data_q;
        bus.prog_ack     = (state_q == ST_PROG);
        bus.in_ready     = (state_q == ST_INPUT);
        bus.busy         = (state_q != ST_IDLE);
        bus.tick_done    = (state_q == ST_DONE);
        bus.evt_count    = evt_count_q;
    end

endmodule

// File: doc/ttt_stage_sequencer.md
Name: ttt_stage_sequencer

Overview:
Stage controller for the ttt main datapath: drives its stage code, processor_id and instruction inputs so one "tick" runs input → process → output in fixed order. Also arbitrates the single datapath between host programming writes and tick execution. Sits between the host I/O shim and the main datapath. Runs on the datapath's clock domain.

Parameters:
NUM_PROCESSORS, 10, processor count; processor_id width PID_W = $clog2(NUM_PROCESSORS)
PROG_WIDTH, 8, programming data width
EVT_CNT_BITS, 8, width of per-tick output-event counter

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low; low forces all state to reset values
start  in  1  request one tick; sampled only in IDLE
prog_req  in  1  host programming write request
prog_instr_in  in  5  host instruction code
prog_data_in  in  PROG_WIDTH  host programming data
prog_ack  out  1  one-cycle pulse: write issued to datapath
in_valid  in  1  external token word present during INPUT
in_last  in  1  marks final input word of the tick
in_ready  out  1  sequencer accepts an input word
dp_output_valid  in  1  datapath output_valid for the current processor_id
out_ready  in  1  downstream can take an output event
stage  out  3  stage code to datapath
processor_id  out  PID_W  processor index to datapath
instruction  out  5  instruction to datapath (0 = NOP)
prog_data  out  PROG_WIDTH  data to datapath
busy  out  1  high in any state except IDLE
tick_done  out  1  one-cycle pulse in DONE
evt_count  out  EVT_CNT_BITS  output events emitted in last completed tick

Behaviour:
- States/stage codes: IDLE=0, PROG=1, INPUT=2, PROCESS=3, OUTPUT=4, DONE=5; stage output equals current state code (registered).
- Reset values: stage=0, processor_id=0, instruction=0, prog_data=0, prog_ack=0, in_ready=0, busy=0, tick_done=0, evt_count=0.
- IDLE: prog_req → PROG; else start → INPUT. prog_req and start same cycle: PROG wins, start dropped (host re-asserts).
- PROG: exactly 1 cycle; instruction=prog_instr_in, prog_data=prog_data_in registered on entry; prog_ack=1; returns to IDLE, instruction back to 0.
- prog_req outside IDLE: ignored, no ack; host holds until prog_ack.
- INPUT: in_ready=1; each cycle with in_valid&in_ready is one accepted word; accepted word with in_last → PROCESS. in_valid low: stall indefinitely. in_last without in_valid: ignored.
- PROCESS: processor_id counts 0..NUM_PROCESSORS-1, one per cycle; after NUM_PROCESSORS-1 → OUTPUT with processor_id=0. Latency NUM_PROCESSORS cycles.
- OUTPUT: scans processor_id 0..NUM_PROCESSORS-1. dp_output_valid=1 and out_ready=0: hold processor_id (stall). dp_output_valid=1 and out_ready=1: count event, advance. dp_output_valid=0: advance without waiting. After last index → DONE.
- Event counter: internal, cleared on INPUT entry, saturates at 2^EVT_CNT_BITS-1; copied to evt_count on DONE entry (stable otherwise).
- DONE: 1 cycle, tick_done=1, → IDLE, processor_id=0.
- start while busy: ignored.
- reset low in any state: immediate return to IDLE with reset values; partial tick discarded, evt_count=0.
- processor_id never exceeds NUM_PROCESSORS-1 (non-power-of-2 wrap explicit).

Optional Feature:
TTT_SEQ_AUTORUN_EN
- Defined: extra input autorun (1 bit). DONE with autorun=1 → INPUT directly (tick_done still pulses); pending prog_req in DONE takes priority and goes PROG→IDLE.
- Undefined: no autorun port; DONE always → IDLE.

Decomposition:
- Package ttt_seq_pkg: enum seq_state_t (codes above, 3-bit), instruction localparam INSTR_NOP=5'd0, stage-code localparams shared with datapath.
- Sub-module ttt_scan_counter: processor_id counter with enable, clear, hold and last-index flag; instantiated once, shared by PROCESS and OUTPUT.

Test Plan:
- Reset mid-OUTPUT (processor_id=4) → all outputs at reset values same cycle reset low; after release stage=0, busy=0.
- prog_req=1, instr=5'd3, data=8'hA5 in IDLE → next cycle stage=1, instruction=3, prog_data=A5, prog_ack=1; following cycle stage=0, instruction=0.
- start & prog_req same cycle → PROG taken, no INPUT; start alone next cycle → stage=2.
- Tick: 3 input words (last on 3rd, one in_valid gap) → PROCESS ids 0..9 in 10 cycles, OUTPUT, DONE; tick_done pulse exactly once.
- OUTPUT with dp_output_valid at ids 2,7 and out_ready low 3 cycles at id 7 → id 7 held 3 cycles, evt_count=2 after DONE.
- With TTT_SEQ_AUTORUN_EN, autorun=1 → DONE followed directly by stage=2, no IDLE cycle; autorun=0 → returns to IDLE.
